// File: rtl/matvec_pkg.sv
// Shared definitions for the matvec sequencer slice.
// Provides the sequencer state encoding and the datapath geometry constants
// (X vector length, byte width, A word width, sum width).
package matvec_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_X,
      RUN,
      DRAIN,
      FIN
   } state_t;

   localparam int unsigned X_BYTES = 9;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned A_W     = 72;
   localparam int unsigned SUM_W   = 20;
   localparam int unsigned XREG_W  = 3 * DATA_W;

endpackage

// File: rtl/matvec_seq_if.sv
// Bundle of the sequencer's host, X-stream, A-SRAM and datapath signals.
//   master : host side (drives start/cfg/X stream, observes everything else)
//   slave  : sequencer side (matvec_seq)
// Signals: start, cfg_rows[AW:0], x_reuse, x_valid, x_data[7:0], x_ready,
//          a_ren, a_addr[AW-1:0], alu_en, x_reg1..3[23:0], res_addr[AW-1:0],
//          busy, done.
interface matvec_seq_if #(
   parameter int unsigned ROWS = 16,
   parameter int unsigned AW   = $clog2(ROWS)
);
   import matvec_pkg::*;

   logic                start;
   logic [AW:0]         cfg_rows;
   logic                x_reuse;
   logic                x_valid;
   logic [DATA_W-1:0]   x_data;
   logic                x_ready;
   logic                a_ren;
   logic [AW-1:0]       a_addr;
   logic                alu_en;
   logic [XREG_W-1:0]   x_reg1;
   logic [XREG_W-1:0]   x_reg2;
   logic [XREG_W-1:0]   x_reg3;
   logic [AW-1:0]       res_addr;
   logic                busy;
   logic                done;

   modport master (
      output start, cfg_rows, x_reuse, x_valid, x_data,
      input  x_ready, a_ren, a_addr, alu_en, x_reg1, x_reg2, x_reg3,
             res_addr, busy, done
   );

   modport slave (
      input  start, cfg_rows, x_reuse, x_valid, x_data,
      output x_ready, a_ren, a_addr, alu_en, x_reg1, x_reg2, x_reg3,
             res_addr, busy, done
   );

endinterface

// File: rtl/matvec_xload.sv
// 9-byte X vector capture with ready/valid.
// Ports:
//   clk, rst      clock, async active-low reset
//   en            capture window (sequencer is in LOAD_X)
//   x_valid       byte valid
//   x_data[7:0]   byte
//   x_ready       equals en
//   x_reg1..3     captured X operands; byte k lands in x_reg[k/3+1][8*(k%3)+:8]
//   load_done     combinational pulse on the cycle the 9th byte is accepted
module matvec_xload
   import matvec_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                x_valid,
   input  logic [DATA_W-1:0]   x_data,
   output logic                x_ready,
   output logic [XREG_W-1:0]   x_reg1,
   output logic [XREG_W-1:0]   x_reg2,
   output logic [XREG_W-1:0]   x_reg3,
   output logic                load_done
);

   logic [3:0]                  byte_cnt;
   logic [X_BYTES*DATA_W-1:0]   xv;
   logic                        beat;

   assign x_ready   = en;
   assign beat      = en & x_valid;
   assign load_done = beat && (byte_cnt == 4'(X_BYTES - 1));

   // Flat byte vector: byte k at xv[8k +: 8], so the three 24-bit operands
   // fall out as consecutive slices.
   assign x_reg1 = xv[XREG_W-1:0];
   assign x_reg2 = xv[2*XREG_W-1:XREG_W];
   assign x_reg3 = xv[3*XREG_W-1:2*XREG_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt <= '0;
         xv       <= '0;
      end else begin
         if (!en) begin
            byte_cnt <= '0;
         end else if (beat) begin
            for (int unsigned k = 0; k < X_BYTES; k++) begin
               if (byte_cnt == 4'(k)) xv[k*DATA_W +: DATA_W] <= x_data;
            end
            byte_cnt <= load_done ? '0 : byte_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/matvec_seq.sv
// Sequencer for the 9-tap multiply/sum datapath.
// Captures the X vector, streams row addresses to the A SRAM (1-cycle read),
// raises alu_en when the A word arrives and presents res_addr aligned with
// the datapath's registered write strobe (two cycles after issue).
// Ports:
//   clk, rst   clock, async active-low reset
//   bus        matvec_seq_if.slave (host control, X stream, A SRAM, datapath)
module matvec_seq
   import matvec_pkg::*;
#(
   parameter int unsigned ROWS = 16,
   parameter int unsigned AW   = $clog2(ROWS)
) (
   input  logic        clk,
   input  logic        rst,
   matvec_seq_if.slave bus
);

   localparam logic [AW:0] ROWS_MAX = (AW+1)'(ROWS);
   localparam logic [AW:0] ROW_ONE  = (AW+1)'(1);

   state_t            state, state_nx;
   logic [AW:0]       rows_r;
   logic [AW:0]       rows_sat;
   logic [AW:0]       row_cnt;
   logic              run_last;
   logic              drain_cnt;
   logic              load_done;
   logic              xload_en;
   logic              a_ren;
   logic              busy;
   logic              done;
   logic              alu_en_r;
   logic [AW-1:0]     addr_d1;
   logic [AW-1:0]     res_addr_r;
   logic              x_ready;
   logic [XREG_W-1:0] x_reg1, x_reg2, x_reg3;

   assign rows_sat = (bus.cfg_rows > ROWS_MAX) ? ROWS_MAX : bus.cfg_rows;
   assign run_last = (row_cnt == rows_r - ROW_ONE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      a_ren    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      xload_en = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (!bus.x_reuse)        state_nx = LOAD_X;
               else if (rows_sat == '0) state_nx = FIN;
               else                     state_nx = RUN;
            end
         end
         LOAD_X: begin
            busy     = 1'b1;
            xload_en = 1'b1;
            if (load_done) state_nx = (rows_r == '0) ? FIN : RUN;
         end
         RUN: begin
            busy  = 1'b1;
            a_ren = 1'b1;
            if (run_last) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_cnt) state_nx = FIN;
         end
         FIN: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- row issue and result pipeline ----------------
   // a_addr is the low bits of the row counter; the counter is cleared on
   // entry to RUN and stops on the last row, so a_addr holds its final value
   // through DRAIN/FIN/IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rows_r     <= '0;
         row_cnt    <= '0;
         drain_cnt  <= 1'b0;
         alu_en_r   <= 1'b0;
         addr_d1    <= '0;
         res_addr_r <= '0;
      end else begin
         if (state == IDLE && bus.start) rows_r <= rows_sat;

         if (state_nx == RUN && state != RUN)
            row_cnt <= '0;
         else if (state == RUN && !run_last)
            row_cnt <= row_cnt + ROW_ONE;

         drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         alu_en_r   <= a_ren;
         addr_d1    <= row_cnt[AW-1:0];
         res_addr_r <= addr_d1;
      end
   end

   matvec_xload u_xload (
      .clk       (clk),
      .rst       (rst),
      .en        (xload_en),
      .x_valid   (bus.x_valid),
      .x_data    (bus.x_data),
      .x_ready   (x_ready),
      .x_reg1    (x_reg1),
      .x_reg2    (x_reg2),
      .x_reg3    (x_reg3),
      .load_done (load_done)
   );

   assign bus.x_ready  = x_ready;
   assign bus.a_ren    = a_ren;
   assign bus.a_addr   = row_cnt[AW-1:0];
   assign bus.alu_en   = alu_en_r;
   assign bus.x_reg1   = x_reg1;
   assign bus.x_reg2   = x_reg2;
   assign bus.x_reg3   = x_reg3;
   assign bus.res_addr = res_addr_r;
   assign bus.busy     = busy;
   assign bus.done     = done;

endmodule

// File: doc/matvec_seq.md
Name: matvec_seq

Overview:
- Sequencer for the 9-tap multiply/sum datapath: captures the 9-byte X vector, streams row addresses to the A-matrix SRAM, and drives the datapath enable and X operand registers.
- Produces result-memory addresses aligned with the datapath's registered write strobe.
- Sits between the host/top-level FSM, the A SRAM (72-bit words, 1-cycle synchronous read) and the multiply/sum datapath.

Parameters:
- ROWS, 16, maximum number of matrix rows (A SRAM depth).
- AW, $clog2(ROWS), width of row and result addresses.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle pulse; begins a job when idle
- cfg_rows  in  AW+1  row count for the job, sampled at start; 0..ROWS
- x_reuse  in  1  sampled at start; 1 = skip X load and keep current X
- x_valid  in  1  X byte stream valid
- x_data  in  8  X byte
- x_ready  out  1  high only in LOAD_X
- a_ren  out  1  A SRAM read enable
- a_addr  out  AW  A SRAM row address
- alu_en  out  1  datapath enable; a_ren delayed 1 cycle
- x_reg1, x_reg2, x_reg3  out  24 each  X operands to the datapath
- res_addr  out  AW  result address; a_addr delayed 2 cycles, valid with the datapath write strobe
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at job end

Behaviour:
- Reset values: all outputs 0; X registers 0; state IDLE. Reset mid-job aborts immediately with no done pulse.
- States: IDLE, LOAD_X, RUN, DRAIN, FIN.
- IDLE:
  - start=1 latches cfg_rows into rows_r and sets busy.
  - Next state is LOAD_X if x_reuse=0, otherwise RUN (or FIN if rows_r=0).
  - start while busy is ignored.
  - cfg_rows > ROWS saturates to ROWS.
- LOAD_X:
  - x_ready=1. Each x_valid&x_ready beat stores byte k (k=0..8) into x_reg[k/3+1] bits [8*(k%3)+7 : 8*(k%3)]. Byte 0 goes to x_reg1[7:0] and byte 8 to x_reg3[23:16].
  - No beat in a cycle means hold.
  - After beat 8, go to RUN, or FIN if rows_r=0. x_ready drops the cycle after beat 8.
- RUN:
  - a_ren=1 every cycle; a_addr counts 0..rows_r-1, one row per cycle, no bubbles.
  - After issuing row rows_r-1, go to DRAIN.
- DRAIN:
  - Lasts exactly 2 cycles so the last alu_en and the datapath write strobe complete.
  - a_ren=0. Then go to FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Latency:
  - a_ren/a_addr issued at cycle t.
  - alu_en=1 at t+1, when A SRAM data arrives.
  - Datapath write strobe and sum at t+2, with res_addr = row issued at t.
- Job duration:
  - x_reuse=1, N rows: start at cycle 0, done at cycle N+3.
  - x_reuse=0 adds the X-load duration.
- X registers change only in LOAD_X, so they are stable throughout RUN/DRAIN.
- a_addr holds its last value when a_ren=0. res_addr pipeline registers reset to 0.
- Counter widths: row counter AW+1 bits, so rows_r=ROWS terminates without wrap. Byte counter 4 bits.

Decomposition:
- Shared package matvec_pkg: state enum (IDLE, LOAD_X, RUN, DRAIN, FIN), X_BYTES=9, DATA_W=8, A_W=72, SUM_W=20.
- One natural sub-module: matvec_xload, the 9-byte X capture shift/index register with ready/valid, which emits x_reg1..3 and a load-complete pulse.

Test Plan:
- Reset check: assert rst low mid-RUN with N=4 -> all outputs 0 next edge, no done; after release, a start with N=2 completes normally.
- Full job: start with x_reuse=0, N=3, X bytes 1..9 back-to-back.
  - x_reg1=0x030201, x_reg2=0x060504, x_reg3=0x090807.
  - a_addr 0,1,2 on consecutive cycles; alu_en one cycle later; res_addr 0,1,2 two cycles later; done 3 cycles after the last issue.
- Stalled X stream: x_valid toggling 1,0,1,0 for 9 beats -> exactly 9 bytes captured in order, RUN entered only after the 9th beat.
- Reuse and zero rows:
  - x_reuse=1, N=ROWS=16: no x_ready; a_addr 0..15, no wrap; done at cycle 19.
  - cfg_rows=0: no a_ren, done after X load.
- Start while busy: pulse start during RUN with different cfg_rows -> ignored, the original row count completes. cfg_rows=20 saturates to 16.
